// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hold codes understood by the PC
// register and stage registers, redirect enable levels and the
// interrupt-entry state encoding.
package pipe_ctrl_pkg;

   // Hold request codes; the PC register freezes for any value >= Pause_Pc
   typedef enum logic [2:0] {
      Hold_None = 3'd0,
      Pause_Pc  = 3'd1,
      Pause_If  = 3'd2,
      Pause_Id  = 3'd3
   } hold_e;

   localparam logic JumpEnable  = 1'b1;
   localparam logic JumpDisable = 1'b0;

   // Interrupt-entry sequencing
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      INT_ENTRY = 2'd1,
      INT_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath/CLINT and the pipeline controller.
// The master side is the datapath (drives requests), the slave side is
// the controller (drives redirect/hold/ack).
interface pipe_ctrl_if;

   logic        ex_jump_i;
   logic [31:0] ex_jaddr_i;
   logic        ex_hold_i;
   logic        bus_hold_i;
   logic        int_req_i;
   logic [31:0] int_vec_i;
   logic [31:0] id_pc_i;
   logic        id_valid_i;

   logic        jump_flag_o;
   logic [31:0] jump_addr_o;
   logic [2:0]  hold_flag_o;
   logic        int_ack_o;
   logic [31:0] mepc_o;

   modport master (
      output ex_jump_i, ex_jaddr_i, ex_hold_i, bus_hold_i,
             int_req_i, int_vec_i, id_pc_i, id_valid_i,
      input  jump_flag_o, jump_addr_o, hold_flag_o, int_ack_o, mepc_o
   );

   modport slave (
      input  ex_jump_i, ex_jaddr_i, ex_hold_i, bus_hold_i,
             int_req_i, int_vec_i, id_pc_i, id_valid_i,
      output jump_flag_o, jump_addr_o, hold_flag_o, int_ack_o, mepc_o
   );

endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges EX redirects, EX multi-cycle holds, bus
// waits and CLINT interrupts into one PC redirect plus a hold code, and
// sequences interrupt entry (freeze PC, redirect to vector, save mepc).
// Optional build macro PIPE_CTRL_PERF_EN adds stall/flush cycle counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0
)
(
   input  logic        clk,
   input  logic        rst_n,
   pipe_ctrl_if.slave  ctrl
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_o,
   output logic [31:0] perf_flush_o
`endif
);

   state_e      state_q, state_d;
   logic [31:0] mepc_q, mepc_d;

   logic        jumpFlag;
   logic [31:0] jumpAddr;
   hold_e       holdFlag;
   logic        intAck;

   // The reset vector itself is applied by the PC register on reset; the
   // controller only has to stay silent while reset is asserted.
   logic        unusedResetAddr;
   assign unusedResetAddr = ^RESET_ADDR;

   // State and saved return PC; async reset abandons any entry in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mepc_q  <= '0;
      end else begin
         state_q <= state_d;
         mepc_q  <= mepc_d;
      end
   end

   // Request arbitration and entry sequencing; outputs forced quiet in reset
   always_comb begin
      state_d  = state_q;
      mepc_d   = mepc_q;
      jumpFlag = JumpDisable;
      jumpAddr = '0;
      holdFlag = Hold_None;
      intAck   = 1'b0;
      if (rst_n) begin
         case (state_q)
            IDLE, INT_DONE: begin
               if (ctrl.ex_jump_i) begin
                  jumpFlag = JumpEnable;
                  jumpAddr = ctrl.ex_jaddr_i;
                  holdFlag = Pause_Id;
               end else if (ctrl.ex_hold_i) begin
                  holdFlag = Pause_Id;
               end else if (ctrl.bus_hold_i) begin
                  holdFlag = Pause_If;
               end else if ((state_q == IDLE) && ctrl.int_req_i && ctrl.id_valid_i) begin
                  holdFlag = Pause_Pc;
                  state_d  = INT_ENTRY;
               end
               if ((state_q == INT_DONE) && !ctrl.int_req_i) begin
                  state_d = IDLE;
               end
            end
            INT_ENTRY: begin
               jumpFlag = JumpEnable;
               jumpAddr = ctrl.int_vec_i;
               holdFlag = Pause_Id;
               intAck   = 1'b1;
               mepc_d   = ctrl.id_pc_i;
               state_d  = INT_DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign ctrl.jump_flag_o = jumpFlag;
   assign ctrl.jump_addr_o = jumpAddr;
   assign ctrl.hold_flag_o = holdFlag;
   assign ctrl.int_ack_o   = intAck;
   assign ctrl.mepc_o      = mepc_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_flush_q, perf_flush_d;

   // Count stalled and redirected cycles; both wrap naturally at 2^32
   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_flush_d = perf_flush_q;
      if (holdFlag != Hold_None) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
      if (jumpFlag == JumpEnable) begin
         perf_flush_d = perf_flush_q + 32'd1;
      end
   end

   // Performance counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall_o = perf_stall_q;
   assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by
// randomized traffic, all compared against a rule-level reference model.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perfStall;
   logic [31:0] perfFlush;
`endif

   pipe_ctrl #(.RESET_ADDR(32'h0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (bus)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_o (perfStall),
      .perf_flush_o (perfFlush)
`endif
   );

   int checks = 0;
   int failures = 0;

   // Reference model: "an interrupt was accepted last cycle" and
   // "an ack was given and the request has not yet dropped"
   bit          mEntering = 0;
   bit          mBlocked = 0;
   logic [31:0] mMepc = '0;
   logic [31:0] mStall = '0;
   logic [31:0] mFlush = '0;

   // Compare one observed value against its expectation
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, check same-cycle outputs, then the registered ones
   task automatic applyStimulus(input logic jmp, input logic [31:0] jaddr,
                                input logic exh, input logic bush, input logic req,
                                input logic [31:0] vec, input logic [31:0] pc,
                                input logic valid, input string tag);
      logic        eJump;
      logic [31:0] eAddr;
      logic [2:0]  eHold;
      logic        eAck;
      bit          accept;
      @(negedge clk);
      bus.ex_jump_i  = jmp;
      bus.ex_jaddr_i = jaddr;
      bus.ex_hold_i  = exh;
      bus.bus_hold_i = bush;
      bus.int_req_i  = req;
      bus.int_vec_i  = vec;
      bus.id_pc_i    = pc;
      bus.id_valid_i = valid;
      #1;
      eJump = 0; eAddr = '0; eHold = 3'd0; eAck = 0; accept = 0;
      if (mEntering) begin
         eJump = 1; eAddr = vec; eHold = 3'd3; eAck = 1;
      end else if (jmp) begin
         eJump = 1; eAddr = jaddr; eHold = 3'd3;
      end else if (exh) begin
         eHold = 3'd3;
      end else if (bush) begin
         eHold = 3'd2;
      end else if (req && valid && !mBlocked) begin
         eHold = 3'd1; accept = 1;
      end
      checkOutput({tag, ":jump_flag"}, {31'd0, bus.jump_flag_o}, {31'd0, eJump});
      checkOutput({tag, ":jump_addr"}, bus.jump_addr_o, eAddr);
      checkOutput({tag, ":hold_flag"}, {29'd0, bus.hold_flag_o}, {29'd0, eHold});
      checkOutput({tag, ":int_ack"}, {31'd0, bus.int_ack_o}, {31'd0, eAck});
      @(posedge clk);
      #1;
      if (mEntering) begin
         mMepc = pc;
         mBlocked = 1;
         mEntering = 0;
      end else begin
         if (!req) mBlocked = 0;
         mEntering = accept;
      end
      if (eHold != 3'd0) mStall = mStall + 32'd1;
      if (eJump) mFlush = mFlush + 32'd1;
      checkOutput({tag, ":mepc"}, bus.mepc_o, mMepc);
`ifdef PIPE_CTRL_PERF_EN
      checkOutput({tag, ":perf_stall"}, perfStall, mStall);
      checkOutput({tag, ":perf_flush"}, perfFlush, mFlush);
`endif
   endtask

   task automatic quiet(input string tag);
      applyStimulus(0, '0, 0, 0, 0, '0, '0, 0, tag);
   endtask

   initial begin
      bit req;
      logic [31:0] vec;
      logic [31:0] pc;

      // Reset with requests active: outputs must stay quiet
      bus.ex_jump_i  = 1;
      bus.ex_jaddr_i = 32'h1234;
      bus.ex_hold_i  = 1;
      bus.bus_hold_i = 0;
      bus.int_req_i  = 1;
      bus.int_vec_i  = 32'h200;
      bus.id_pc_i    = 32'h40;
      bus.id_valid_i = 1;
      #12;
      checkOutput("reset:jump_flag", {31'd0, bus.jump_flag_o}, 32'd0);
      checkOutput("reset:jump_addr", bus.jump_addr_o, 32'd0);
      checkOutput("reset:hold_flag", {29'd0, bus.hold_flag_o}, 32'd0);
      checkOutput("reset:int_ack", {31'd0, bus.int_ack_o}, 32'd0);
      checkOutput("reset:mepc", bus.mepc_o, 32'd0);
      @(negedge clk);
      bus.ex_jump_i = 0; bus.ex_hold_i = 0; bus.int_req_i = 0; bus.id_valid_i = 0;
      rst_n = 1;

      // EX redirect
      applyStimulus(1, 32'h100, 0, 0, 0, '0, '0, 1, "jump");
      quiet("jump_after");

      // Divider busy for five cycles
      for (int i = 0; i < 5; i++) applyStimulus(0, '0, 1, 0, 0, '0, '0, 1, "exhold");
      quiet("exhold_after");

      // Interrupt entry, request held high after the ack
      for (int i = 0; i < 5; i++) applyStimulus(0, '0, 0, 0, 1, 32'h200, 32'h40, 1, "irq");
      checkOutput("irq:mepc_const", bus.mepc_o, 32'h40);
      quiet("irq_drop");
      quiet("irq_idle");

      // Interrupt deferred behind bus wait
      for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, 1, 1, 32'h300, 32'h88, 1, "busirq");
      for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, 0, 1, 32'h300, 32'h88, 1, "busirq_go");
      quiet("busirq_drop");
      quiet("busirq_idle");

      // Async reset while the entry cycle is active
      applyStimulus(0, '0, 0, 0, 1, 32'h400, 32'h90, 1, "rstmid_req");
      @(negedge clk);
      #2;
      rst_n = 0;
      #1;
      checkOutput("rstmid:jump_flag", {31'd0, bus.jump_flag_o}, 32'd0);
      checkOutput("rstmid:jump_addr", bus.jump_addr_o, 32'd0);
      checkOutput("rstmid:hold_flag", {29'd0, bus.hold_flag_o}, 32'd0);
      checkOutput("rstmid:int_ack", {31'd0, bus.int_ack_o}, 32'd0);
      checkOutput("rstmid:mepc", bus.mepc_o, 32'd0);
      bus.int_req_i = 0;
      @(posedge clk);
      #1;
      checkOutput("rstmid_hold:int_ack", {31'd0, bus.int_ack_o}, 32'd0);
      checkOutput("rstmid_hold:mepc", bus.mepc_o, 32'd0);
      mEntering = 0; mBlocked = 0; mMepc = '0; mStall = '0; mFlush = '0;
      @(negedge clk);
      rst_n = 1;
      quiet("rstmid_after");

      // Four hold cycles and two redirects
      for (int i = 0; i < 4; i++) applyStimulus(0, '0, i[0], ~i[0], 0, '0, '0, 1, "perf_hold");
      applyStimulus(1, 32'h500, 0, 0, 0, '0, '0, 1, "perf_jump0");
      applyStimulus(1, 32'h600, 0, 0, 0, '0, '0, 1, "perf_jump1");
`ifdef PIPE_CTRL_PERF_EN
      checkOutput("perf:stall_total", perfStall, 32'd6);
      checkOutput("perf:flush_total", perfFlush, 32'd2);
`endif

      // Randomized traffic with a level interrupt source
      req = 0;
      vec = 32'h800;
      pc  = 32'h1000;
      for (int i = 0; i < 2000; i++) begin
         if (!req && ($urandom_range(7) == 0)) begin
            req = 1;
            vec = {$urandom_range(32'hFFFF), 2'b00};
         end else if (req && mBlocked && ($urandom_range(2) == 0)) begin
            req = 0;
         end
         pc = {$urandom, 2'b00} >> 2 << 2;
         applyStimulus($urandom_range(4) == 0, $urandom,
                       $urandom_range(4) == 0, $urandom_range(4) == 0,
                       req, vec, pc, $urandom_range(3) != 0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
